// File: rtl/mmio_pkg.sv
// Shared constants, decode result type and address decoder for the MMIO port bank.
package mmio_pkg;

    localparam logic [31:0] MMIO_TOP      = 32'hFFFF_FFFC;
    localparam logic [31:0] IRQ_MASK_ADDR = 32'hFFFF_FF00;
    localparam int unsigned CH_STRIDE     = 8;

    localparam int unsigned STAT_RX_NONEMPTY  = 0;
    localparam int unsigned STAT_TX_NOTFULL   = 1;
    localparam int unsigned STAT_TX_OVF       = 2;
    localparam int unsigned STAT_RX_UNDER     = 3;
    localparam int unsigned STAT_RX_COUNT_LSB = 8;
    localparam int unsigned STAT_TX_COUNT_LSB = 16;
    localparam int unsigned STAT_COUNT_W      = 4;

    typedef struct packed {
        logic       hit;
        logic       is_stat;
        logic [2:0] ch;
    } mmio_dec_t;

    // Channels grow downward from MMIO_TOP; offset bit 2 separates DATA (0) from STAT (1).
    function automatic mmio_dec_t mmio_decode(input logic [31:0] addr, input int unsigned num_ch);
        logic [31:0] diff;
        mmio_dec_t   d;
        diff = MMIO_TOP - addr;
        d    = '0;
        if (diff[1:0] == 2'b00 && diff < 32'(num_ch * CH_STRIDE)) begin
            d.hit     = 1'b1;
            d.is_stat = diff[2];
            d.ch      = diff[5:3];
        end
        return d;
    endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Single-clock FIFO with occupancy count and zero-when-empty head output.
module mmio_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_port_bank.sv
// Multi-channel MMIO bank: per-channel RX/TX FIFOs behind DATA/STAT words on the data bus.
// Optional interrupt output and mask register enabled by defining MMIO_IRQ_EN.
module mmio_port_bank
    import mmio_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic [31:0]             Addr,
    input  logic [31:0]             WData,
    input  logic                    WE,
    input  logic                    RE,
    output logic [31:0]             RData,
    output logic                    Hit,
`ifdef MMIO_IRQ_EN
    output logic                    IRQ,
`endif
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [NUM_CH-1:0]       out_valid,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    input  logic [NUM_CH-1:0]       out_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    mmio_dec_t         dec;
    logic [NUM_CH-1:0] data_hit;
    logic [NUM_CH-1:0] stat_hit;

    logic [NUM_CH-1:0] rx_push, rx_pop, rx_full, rx_empty;
    logic [NUM_CH-1:0] tx_push, tx_pop, tx_full, tx_empty;
    logic [NUM_CH-1:0] tx_ovf, rx_under;
    logic [CW-1:0]     rx_count [NUM_CH];
    logic [CW-1:0]     tx_count [NUM_CH];
    logic [WIDTH-1:0]  rx_head  [NUM_CH];
    logic [WIDTH-1:0]  tx_head  [NUM_CH];
    logic [31:0]       stat     [NUM_CH];

    always_comb begin
        dec      = mmio_decode(Addr, NUM_CH);
        data_hit = '0;
        stat_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (dec.hit && dec.ch == 3'(c)) begin
                data_hit[c] = ~dec.is_stat;
                stat_hit[c] = dec.is_stat;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        // A full RX never accepts, even when the CPU pops in the same cycle.
        assign rx_push[c] = in_valid[c] & ~rx_full[c];
        assign rx_pop[c]  = RE & data_hit[c] & ~rx_empty[c];
        assign tx_push[c] = WE & data_hit[c] & ~tx_full[c];
        assign tx_pop[c]  = out_ready[c] & ~tx_empty[c];

        mmio_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx (
            .clk   (CLK),
            .reset (Reset),
            .push  (rx_push[c]),
            .pop   (rx_pop[c]),
            .din   (in_data[c*WIDTH +: WIDTH]),
            .full  (rx_full[c]),
            .empty (rx_empty[c]),
            .count (rx_count[c]),
            .head  (rx_head[c])
        );

        mmio_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx (
            .clk   (CLK),
            .reset (Reset),
            .push  (tx_push[c]),
            .pop   (tx_pop[c]),
            .din   (WData[WIDTH-1:0]),
            .full  (tx_full[c]),
            .empty (tx_empty[c]),
            .count (tx_count[c]),
            .head  (tx_head[c])
        );

        assign in_ready[c]                  = ~rx_full[c];
        assign out_valid[c]                 = ~tx_empty[c];
        assign out_data[c*WIDTH +: WIDTH]   = tx_head[c];
    end

    // Sticky error flags; a set in the same cycle as a W1C clear wins.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            tx_ovf   <= '0;
            rx_under <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (WE && data_hit[c] && tx_full[c])
                    tx_ovf[c] <= 1'b1;
                else if (WE && stat_hit[c] && WData[STAT_TX_OVF])
                    tx_ovf[c] <= 1'b0;

                if (RE && data_hit[c] && rx_empty[c])
                    rx_under[c] <= 1'b1;
                else if (WE && stat_hit[c] && WData[STAT_RX_UNDER])
                    rx_under[c] <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            stat[c]                   = '0;
            stat[c][STAT_RX_NONEMPTY] = ~rx_empty[c];
            stat[c][STAT_TX_NOTFULL]  = ~tx_full[c];
            stat[c][STAT_TX_OVF]      = tx_ovf[c];
            stat[c][STAT_RX_UNDER]    = rx_under[c];
            stat[c][STAT_RX_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(rx_count[c]);
            stat[c][STAT_TX_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(tx_count[c]);
        end
    end

`ifdef MMIO_IRQ_EN
    logic [NUM_CH-1:0] irq_mask;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            irq_mask <= '0;
            IRQ      <= 1'b0;
        end else begin
            if (WE && Addr == IRQ_MASK_ADDR) irq_mask <= WData[NUM_CH-1:0];
            IRQ <= (|(~rx_empty & irq_mask)) | (|(tx_ovf & irq_mask));
        end
    end
`endif

    // Load path is purely combinational from Addr and pre-edge FIFO state.
    always_comb begin
        RData = '0;
        Hit   = dec.hit;
        for (int c = 0; c < NUM_CH; c++) begin
            if (dec.hit && dec.ch == 3'(c))
                RData = dec.is_stat ? stat[c] : 32'(rx_head[c]);
        end
`ifdef MMIO_IRQ_EN
        if (Addr == IRQ_MASK_ADDR) begin
            Hit   = 1'b1;
            RData = 32'(irq_mask);
        end
`endif
    end

endmodule

// File: tb/tb_mmio_port_bank.sv
// Scoreboard bench for mmio_port_bank: stimulus queues expectations, a negedge monitor checks them.
module tb_mmio_port_bank;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned WIDTH  = 32;

    logic                    CLK = 1'b0;
    logic                    Reset;
    logic [31:0]             Addr;
    logic [31:0]             WData;
    logic                    WE;
    logic                    RE;
    logic [31:0]             RData;
    logic                    Hit;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_ready;
    logic [NUM_CH-1:0]       out_valid;
    logic [NUM_CH*WIDTH-1:0] out_data;
    logic [NUM_CH-1:0]       out_ready;
`ifdef MMIO_IRQ_EN
    logic                    IRQ;
`endif

    mmio_port_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(4)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Addr      (Addr),
        .WData     (WData),
        .WE        (WE),
        .RE        (RE),
        .RData     (RData),
        .Hit       (Hit),
`ifdef MMIO_IRQ_EN
        .IRQ       (IRQ),
`endif
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        logic        hit;
        string       name;
    } rd_exp_t;

    typedef struct {
        int          ch;
        logic [31:0] data;
    } tx_exp_t;

    typedef struct {
        logic [3:0]  rdy;
        logic [3:0]  vld;
        logic [31:0] od0;
        logic        irq;
        string       name;
    } probe_exp_t;

    rd_exp_t    rd_q [$];
    tx_exp_t    tx_q [$];
    probe_exp_t pr_q [$];
    logic       probe = 1'b0;
    int         checks = 0;
    int         errors = 0;

    function automatic logic [31:0] data_addr(input int c);
        return 32'hFFFF_FFFC - 32'(8 * c);
    endfunction

    function automatic logic [31:0] stat_addr(input int c);
        return 32'hFFFF_FFF8 - 32'(8 * c);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT is presenting this cycle against queued expectations.
    always @(negedge CLK) begin
        if (RE) begin
            if (rd_q.size() == 0) begin
                chk("rd_queue_empty", 32'd1, 32'd0);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk({e.name, "_rdata"}, RData, e.data);
                chk({e.name, "_hit"}, 32'(Hit), 32'(e.hit));
            end
        end
        if (probe) begin
            if (pr_q.size() == 0) begin
                chk("probe_queue_empty", 32'd1, 32'd0);
            end else begin
                probe_exp_t p;
                p = pr_q.pop_front();
                chk({p.name, "_in_ready"}, 32'(in_ready), 32'(p.rdy));
                chk({p.name, "_out_valid"}, 32'(out_valid), 32'(p.vld));
                chk({p.name, "_out_data0"}, out_data[31:0], p.od0);
`ifdef MMIO_IRQ_EN
                chk({p.name, "_irq"}, 32'(IRQ), 32'(p.irq));
`endif
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (out_valid[c] && out_ready[c]) begin
                if (tx_q.size() == 0) begin
                    chk("tx_queue_empty", 32'd1, 32'd0);
                end else begin
                    tx_exp_t t;
                    t = tx_q.pop_front();
                    chk("tx_channel", 32'(c), 32'(t.ch));
                    chk("tx_data", out_data[c*WIDTH +: WIDTH], t.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd_setup(input logic [31:0] a, input logic [31:0] exp, input logic hit, input string nm);
        rd_exp_t e;
        e.data = exp;
        e.hit  = hit;
        e.name = nm;
        rd_q.push_back(e);
        Addr = a;
        RE   = 1'b1;
    endtask

    task automatic lw(input logic [31:0] a, input logic [31:0] exp, input string nm);
        rd_setup(a, exp, 1'b1, nm);
        tick();
        RE   = 1'b0;
        Addr = '0;
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        Addr  = a;
        WData = d;
        WE    = 1'b1;
        tick();
        WE    = 1'b0;
        Addr  = '0;
    endtask

    task automatic push_rx(input int c, input logic [31:0] d);
        in_valid[c]           = 1'b1;
        in_data[c*WIDTH +: WIDTH] = d;
        tick();
        in_valid[c]           = 1'b0;
    endtask

    task automatic lw_push(input logic [31:0] a, input logic [31:0] exp, input string nm,
                           input int c, input logic [31:0] d);
        rd_setup(a, exp, 1'b1, nm);
        in_valid[c]           = 1'b1;
        in_data[c*WIDTH +: WIDTH] = d;
        tick();
        in_valid[c] = 1'b0;
        RE          = 1'b0;
        Addr        = '0;
    endtask

    task automatic do_probe(input logic [3:0] rdy, input logic [3:0] vld, input logic [31:0] od0,
                            input logic irq, input string nm);
        probe_exp_t p;
        p.rdy  = rdy;
        p.vld  = vld;
        p.od0  = od0;
        p.irq  = irq;
        p.name = nm;
        pr_q.push_back(p);
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    task automatic exp_tx(input int c, input logic [31:0] d);
        tx_exp_t t;
        t.ch   = c;
        t.data = d;
        tx_q.push_back(t);
    endtask

    initial begin
        Reset     = 1'b1;
        Addr      = '0;
        WData     = '0;
        WE        = 1'b0;
        RE        = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '0;
        tick();
        Reset = 1'b0;

        // Reset state and address map edges
        do_probe(4'hF, 4'h0, 32'h0, 1'b0, "reset");
        lw(stat_addr(0), 32'h0000_0002, "reset_stat0");
        rd_setup(32'h0000_1000, 32'h0, 1'b0, "unmapped");
        tick();
        rd_setup(32'hFFFF_FFFE, 32'h0, 1'b0, "misaligned");
        tick();
        rd_setup(32'hFFFF_FFDC, 32'h0, 1'b0, "past_last_ch");
        tick();
        RE = 1'b0;
        Addr = '0;

        // RX pop and underflow with W1C
        push_rx(0, 32'd8);
        lw(data_addr(0), 32'd8, "rx0_pop");
        lw(stat_addr(0), 32'h0000_0002, "rx0_empty");
        lw(data_addr(0), 32'd0, "rx0_under_rd");
        lw(stat_addr(0), 32'h0000_000A, "rx0_under_set");
        sw(stat_addr(0), 32'd8);
        lw(stat_addr(0), 32'h0000_0002, "rx0_under_clr");

        // RX fill, overflow drop, simultaneous pop/push
        for (int i = 1; i <= 4; i++) push_rx(1, 32'(i));
        do_probe(4'b1101, 4'h0, 32'h0, 1'b0, "rx1_full");
        push_rx(1, 32'd5);
        lw(stat_addr(1), 32'h0000_0403, "rx1_stat_full");
        lw_push(data_addr(1), 32'd1, "rx1_pop_full", 1, 32'd6);
        lw(stat_addr(1), 32'h0000_0303, "rx1_full_nopush");
        lw_push(data_addr(1), 32'd2, "rx1_pop_push", 1, 32'd7);
        lw(stat_addr(1), 32'h0000_0303, "rx1_count_kept");
        lw(data_addr(1), 32'd3, "rx1_drain0");
        lw(data_addr(1), 32'd4, "rx1_drain1");
        lw(data_addr(1), 32'd7, "rx1_drain2");
        lw(stat_addr(1), 32'h0000_0002, "rx1_empty");

        // TX fill, overflow, drain order
        sw(data_addr(0), 32'd50);
        do_probe(4'hF, 4'h1, 32'd50, 1'b0, "tx0_head");
        sw(data_addr(0), 32'hFFFF_FFD6);
        sw(data_addr(0), 32'd3);
        sw(data_addr(0), 32'd4);
        lw(stat_addr(0), 32'h0004_0000, "tx0_full");
        sw(data_addr(0), 32'd5);
        lw(stat_addr(0), 32'h0004_0004, "tx0_ovf");
        exp_tx(0, 32'd50);
        exp_tx(0, 32'hFFFF_FFD6);
        exp_tx(0, 32'd3);
        exp_tx(0, 32'd4);
        out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        out_ready[0] = 1'b0;
        lw(stat_addr(0), 32'h0000_0006, "tx0_drained");
        sw(stat_addr(0), 32'd4);
        lw(stat_addr(0), 32'h0000_0002, "tx0_ovf_clr");

        // Load and store on the same DATA word in one cycle
        push_rx(0, 32'd9);
        rd_setup(data_addr(0), 32'd9, 1'b1, "rw_same");
        WData = 32'd11;
        WE    = 1'b1;
        tick();
        RE = 1'b0;
        WE = 1'b0;
        Addr = '0;
        lw(stat_addr(0), 32'h0001_0002, "rw_stat");
        exp_tx(0, 32'd11);
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;

        // Mid-operation reset discards contents and flags
        push_rx(2, 32'hAA);
        push_rx(2, 32'hBB);
        sw(data_addr(3), 32'hCC);
        sw(data_addr(3), 32'hDD);
        lw(data_addr(0), 32'd0, "pre_rst_under");
        lw(stat_addr(2), 32'h0000_0203, "pre_rst_rx2");
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        lw(stat_addr(0), 32'h0000_0002, "rst_stat0");
        lw(stat_addr(2), 32'h0000_0002, "rst_stat2");
        lw(stat_addr(3), 32'h0000_0002, "rst_stat3");
        do_probe(4'hF, 4'h0, 32'h0, 1'b0, "post_rst");

`ifdef MMIO_IRQ_EN
        sw(32'hFFFF_FF00, 32'h4);
        lw(32'hFFFF_FF00, 32'h4, "irq_mask_rd");
        push_rx(2, 32'h77);
        do_probe(4'hF, 4'h0, 32'h0, 1'b0, "irq_lag");
        do_probe(4'hF, 4'h0, 32'h0, 1'b1, "irq_set");
        lw(data_addr(2), 32'h77, "irq_pop");
        tick();
        do_probe(4'hF, 4'h0, 32'h0, 1'b0, "irq_clr");
`else
        rd_setup(32'hFFFF_FF00, 32'h0, 1'b0, "irq_mask_unmapped");
        tick();
        RE = 1'b0;
        Addr = '0;
`endif

        for (int i = 0; i < 20 && (rd_q.size() + tx_q.size() + pr_q.size()) != 0; i++) tick();
        chk("pending_expectations", 32'(rd_q.size() + tx_q.size() + pr_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
